// File: rtl/wb_stage.sv
// wb_stage: final pipeline stage.
// Registers the LSU->WB bundle and waits for the data-memory response on loads and stores.
// Aligns and extends load data, then drives the register-file write port, which also serves as
// the forwarding source for earlier stages. Raises wb2ac_hazard while a memory response is
// outstanding.
// Optional feature: define WB_INSTRET_EN to add the 64-bit wb2csr_instret retired-instruction counter.
module wb_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu2wb_valid,
  input  logic [XLEN-1:0] lsu2wb_pc,
  input  logic [XLEN-1:0] lsu2wb_inst,
  input  logic [RD_W-1:0] lsu2wb_rd,
  input  logic            lsu2wb_rf_we,
  input  logic            lsu2wb_rf_rd_sel1,
  input  logic [XLEN-1:0] lsu2wb_dout,
  input  logic            lsu2wb_mem_valid,
  input  logic [2:0]      lsu2wb_mem_byte_sel,
  input  logic [1:0]      lsu2wb_mem_addr_offset,
  input  logic            dmem_resp_valid,
  output logic            dmem_resp_ready,
  input  logic [XLEN-1:0] dmem_resp_data,
  input  logic            ac2wb_flush,
  input  logic            ac2wb_stall,
  output logic            wb2rf_wren,
  output logic [RD_W-1:0] wb2rf_waddr,
  output logic [XLEN-1:0] wb2rf_wdata,
  output logic            wb2ac_hazard
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     wb2csr_instret
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q;

  logic            slot_valid;
  logic [XLEN-1:0] slot_pc;
  logic [XLEN-1:0] slot_inst;
  logic [RD_W-1:0] slot_rd;
  logic            slot_rf_we;
  logic            slot_rd_sel1;
  logic [XLEN-1:0] slot_dout;
  logic            slot_mem_valid;
  logic [2:0]      slot_byte_sel;
  logic [1:0]      slot_offset;

  logic            slot_is_mem;
  logic            completing;
  logic            retire;
  logic [XLEN-1:0] shifted_b;
  logic [XLEN-1:0] shifted_h;
  logic [XLEN-1:0] load_data;
  logic            trace_unused;

  // PC and instruction word are carried for tracing only and feed no logic.
  assign trace_unused = ^{slot_pc, slot_inst};

  assign slot_is_mem     = slot_valid && slot_mem_valid;
  assign dmem_resp_ready = 1'b1;

  // Hazard covers a pending response both for a live instruction and for one being drained after a flush.
  assign wb2ac_hazard = !dmem_resp_valid && (slot_is_mem || (state_q == DRAIN));

  // Non-mem instructions finish immediately; mem instructions finish on the response unless draining.
  assign completing = !slot_mem_valid || ((state_q != DRAIN) && dmem_resp_valid);
  assign retire     = slot_valid && !ac2wb_flush && completing;

  // Halfwords use only offset[1] so a misaligned halfword lands on the same lane the LSU strobed.
  assign shifted_b = dmem_resp_data >> {slot_offset, 3'b000};
  assign shifted_h = dmem_resp_data >> {slot_offset[1], 4'b0000};

  // Select and extend the load lane according to the funct3 size/sign encoding.
  always_comb begin
    load_data = '0;
    case (slot_byte_sel)
      3'b000:  load_data = {{(XLEN-8){shifted_b[7]}}, shifted_b[7:0]};
      3'b001:  load_data = {{(XLEN-16){shifted_h[15]}}, shifted_h[15:0]};
      3'b010:  load_data = dmem_resp_data;
      3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted_b[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted_h[15:0]};
      default: load_data = '0;
    endcase
  end

  assign wb2rf_wren  = retire && slot_rf_we && (slot_rd != '0);
  assign wb2rf_waddr = slot_rd;
  assign wb2rf_wdata = slot_rd_sel1 ? load_data : slot_dout;

  // Input register: loads a new bundle only when neither the controller nor our own hazard holds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid     <= 1'b0;
      slot_pc        <= '0;
      slot_inst      <= '0;
      slot_rd        <= '0;
      slot_rf_we     <= 1'b0;
      slot_rd_sel1   <= 1'b0;
      slot_dout      <= '0;
      slot_mem_valid <= 1'b0;
      slot_byte_sel  <= '0;
      slot_offset    <= '0;
    end else if (!ac2wb_stall && !wb2ac_hazard) begin
      slot_valid     <= lsu2wb_valid;
      slot_pc        <= lsu2wb_pc;
      slot_inst      <= lsu2wb_inst;
      slot_rd        <= lsu2wb_rd;
      slot_rf_we     <= lsu2wb_rf_we;
      slot_rd_sel1   <= lsu2wb_rf_rd_sel1;
      slot_dout      <= lsu2wb_dout;
      slot_mem_valid <= lsu2wb_mem_valid;
      slot_byte_sel  <= lsu2wb_mem_byte_sel;
      slot_offset    <= lsu2wb_mem_addr_offset;
    end
  end

  // Response tracker: WAIT for a live load/store, DRAIN to swallow the response of a flushed one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (slot_is_mem && !dmem_resp_valid) begin
            state_q <= ac2wb_flush ? DRAIN : WAIT;
          end
        end
        WAIT: begin
          if (dmem_resp_valid) begin
            state_q <= IDLE;
          end else if (ac2wb_flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (dmem_resp_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WB_INSTRET_EN
  // Retired-instruction counter: counts every valid, unflushed completion, including stores and rd=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb2csr_instret <= 64'd0;
    end else if (retire) begin
      wb2csr_instret <= wb2csr_instret + 64'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A response in IDLE with no memory instruction in the slot breaks the one-response-per-request contract.
  resp_without_request: assert property (
    @(posedge clk) disable iff (rst)
    ((state_q == IDLE) && dmem_resp_valid) |-> slot_is_mem
  );
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
// Build with WB_INSTRET_EN defined to also check the retired-instruction counter.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu2wb_valid;
  logic [31:0] lsu2wb_pc;
  logic [31:0] lsu2wb_inst;
  logic [4:0]  lsu2wb_rd;
  logic        lsu2wb_rf_we;
  logic        lsu2wb_rf_rd_sel1;
  logic [31:0] lsu2wb_dout;
  logic        lsu2wb_mem_valid;
  logic [2:0]  lsu2wb_mem_byte_sel;
  logic [1:0]  lsu2wb_mem_addr_offset;
  logic        dmem_resp_valid;
  logic        dmem_resp_ready;
  logic [31:0] dmem_resp_data;
  logic        ac2wb_flush;
  logic        ac2wb_stall;
  logic        wb2rf_wren;
  logic [4:0]  wb2rf_waddr;
  logic [31:0] wb2rf_wdata;
  logic        wb2ac_hazard;
`ifdef WB_INSTRET_EN
  logic [63:0] wb2csr_instret;
  logic [63:0] instret_base;
`endif

  int errors = 0;
  int checks = 0;

  // Alignment table: funct3, offset, response word, expected write data.
  logic [2:0]  tbl_bsel [6] = '{3'b000, 3'b101, 3'b001, 3'b011, 3'b010, 3'b100};
  logic [1:0]  tbl_off  [6] = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd2, 2'd0};
  logic [31:0] tbl_data [6] = '{32'h1234_5678, 32'h8001_2345, 32'h1234_F00F,
                                32'hFFFF_FFFF, 32'hA5A5_5A5A, 32'h0000_00FF};
  logic [31:0] tbl_exp  [6] = '{32'h0000_0056, 32'h0000_8001, 32'hFFFF_F00F,
                                32'h0000_0000, 32'hA5A5_5A5A, 32'h0000_00FF};

  wb_stage dut (
    .clk                    (clk),
    .rst                    (rst),
    .lsu2wb_valid           (lsu2wb_valid),
    .lsu2wb_pc              (lsu2wb_pc),
    .lsu2wb_inst            (lsu2wb_inst),
    .lsu2wb_rd              (lsu2wb_rd),
    .lsu2wb_rf_we           (lsu2wb_rf_we),
    .lsu2wb_rf_rd_sel1      (lsu2wb_rf_rd_sel1),
    .lsu2wb_dout            (lsu2wb_dout),
    .lsu2wb_mem_valid       (lsu2wb_mem_valid),
    .lsu2wb_mem_byte_sel    (lsu2wb_mem_byte_sel),
    .lsu2wb_mem_addr_offset (lsu2wb_mem_addr_offset),
    .dmem_resp_valid        (dmem_resp_valid),
    .dmem_resp_ready        (dmem_resp_ready),
    .dmem_resp_data         (dmem_resp_data),
    .ac2wb_flush            (ac2wb_flush),
    .ac2wb_stall            (ac2wb_stall),
    .wb2rf_wren             (wb2rf_wren),
    .wb2rf_waddr            (wb2rf_waddr),
    .wb2rf_wdata            (wb2rf_wdata),
    .wb2ac_hazard           (wb2ac_hazard)
`ifdef WB_INSTRET_EN
    ,
    .wb2csr_instret         (wb2csr_instret)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled shortly after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    lsu2wb_valid           = 1'b0;
    lsu2wb_pc              = 32'h0;
    lsu2wb_inst            = 32'h0;
    lsu2wb_rd              = 5'd0;
    lsu2wb_rf_we           = 1'b0;
    lsu2wb_rf_rd_sel1      = 1'b0;
    lsu2wb_dout            = 32'h0;
    lsu2wb_mem_valid       = 1'b0;
    lsu2wb_mem_byte_sel    = 3'b000;
    lsu2wb_mem_addr_offset = 2'd0;
  endtask

  task automatic drive_op(input logic [4:0] rd, input logic we, input logic sel1, input logic memv,
                          input logic [2:0] bsel, input logic [1:0] off, input logic [31:0] dout);
    lsu2wb_valid           = 1'b1;
    lsu2wb_pc              = 32'h0000_1000;
    lsu2wb_inst            = 32'h0000_0013;
    lsu2wb_rd              = rd;
    lsu2wb_rf_we           = we;
    lsu2wb_rf_rd_sel1      = sel1;
    lsu2wb_dout            = dout;
    lsu2wb_mem_valid       = memv;
    lsu2wb_mem_byte_sel    = bsel;
    lsu2wb_mem_addr_offset = off;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_idle();
    dmem_resp_valid = 1'b0; dmem_resp_data = 32'h0; ac2wb_flush = 1'b0; ac2wb_stall = 1'b0;
    tick(); tick();
    checks++; if (wb2rf_wren !== 1'b0) begin errors++; $display("[TB] FAIL reset_wren: got %b expected 0", wb2rf_wren); end
    checks++; if (wb2rf_waddr !== 5'd0) begin errors++; $display("[TB] FAIL reset_waddr: got %0d expected 0", wb2rf_waddr); end
    checks++; if (wb2rf_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", wb2rf_wdata); end
    checks++; if (wb2ac_hazard !== 1'b0) begin errors++; $display("[TB] FAIL reset_hazard: got %b expected 0", wb2ac_hazard); end
    checks++; if (dmem_resp_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", dmem_resp_ready); end
`ifdef WB_INSTRET_EN
    checks++; if (wb2csr_instret !== 64'd0) begin errors++; $display("[TB] FAIL reset_instret: got %0d expected 0", wb2csr_instret); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    drive_op(5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 32'h1234_5678);
    tick(); drive_idle(); #1;
    checks++; if (wb2rf_wren !== 1'b1) begin errors++; $display("[TB] FAIL alu_wren: got %b expected 1", wb2rf_wren); end
    checks++; if (wb2rf_waddr !== 5'd5) begin errors++; $display("[TB] FAIL alu_waddr: got %0d expected 5", wb2rf_waddr); end
    checks++; if (wb2rf_wdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL alu_wdata: got %h expected 12345678", wb2rf_wdata); end
    checks++; if (wb2ac_hazard !== 1'b0) begin errors++; $display("[TB] FAIL alu_hazard: got %b expected 0", wb2ac_hazard); end
    tick();
    checks++; if (wb2rf_wren !== 1'b0) begin errors++; $display("[TB] FAIL alu_wren_after: got %b expected 0", wb2rf_wren); end
  endtask

  task automatic test_lb_immediate();
    logic [2:0]  bsel;
    logic [31:0] expv;
    for (int i = 0; i < 2; i++) begin
      bsel = (i == 0) ? 3'b000 : 3'b100;
      expv = (i == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
      drive_op(5'd7, 1'b1, 1'b1, 1'b1, bsel, 2'd3, 32'h0);
      tick(); drive_idle();
      dmem_resp_valid = 1'b1; dmem_resp_data = 32'h80AA_BBCC; #1;
      checks++; if (wb2rf_wren !== 1'b1) begin errors++; $display("[TB] FAIL lb_wren[%0d]: got %b expected 1", i, wb2rf_wren); end
      checks++; if (wb2rf_waddr !== 5'd7) begin errors++; $display("[TB] FAIL lb_waddr[%0d]: got %0d expected 7", i, wb2rf_waddr); end
      checks++; if (wb2rf_wdata !== expv) begin errors++; $display("[TB] FAIL lb_wdata[%0d]: got %h expected %h", i, wb2rf_wdata, expv); end
      checks++; if (wb2ac_hazard !== 1'b0) begin errors++; $display("[TB] FAIL lb_hazard[%0d]: got %b expected 0", i, wb2ac_hazard); end
      tick(); dmem_resp_valid = 1'b0; #1;
      checks++; if (wb2rf_wren !== 1'b0) begin errors++; $display("[TB] FAIL lb_wren_after[%0d]: got %b expected 0", i, wb2rf_wren); end
      checks++; if (wb2ac_hazard !== 1'b0) begin errors++; $display("[TB] FAIL lb_hazard_after[%0d]: got %b expected 0", i, wb2ac_hazard); end
    end
  endtask

  task automatic test_lh_delayed();
    drive_op(5'd9, 1'b1, 1'b1, 1'b1, 3'b001, 2'd2, 32'h0);
    tick(); drive_idle(); #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (wb2ac_hazard !== 1'b1) begin errors++; $display("[TB] FAIL lh_hazard_wait[%0d]: got %b expected 1", c, wb2ac_hazard); end
      checks++; if (wb2rf_wren !== 1'b0) begin errors++; $display("[TB] FAIL lh_wren_wait[%0d]: got %b expected 0", c, wb2rf_wren); end
      tick();
    end
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'h7FFE_0000; #1;
    checks++; if (wb2ac_hazard !== 1'b0) begin errors++; $display("[TB] FAIL lh_hazard_done: got %b expected 0", wb2ac_hazard); end
    checks++; if (wb2rf_wren !== 1'b1) begin errors++; $display("[TB] FAIL lh_wren_done: got %b expected 1", wb2rf_wren); end
    checks++; if (wb2rf_waddr !== 5'd9) begin errors++; $display("[TB] FAIL lh_waddr: got %0d expected 9", wb2rf_waddr); end
    checks++; if (wb2rf_wdata !== 32'h0000_7FFE) begin errors++; $display("[TB] FAIL lh_wdata: got %h expected 00007ffe", wb2rf_wdata); end
    tick(); dmem_resp_valid = 1'b0; #1;
    checks++; if (wb2rf_wren !== 1'b0) begin errors++; $display("[TB] FAIL lh_wren_once: got %b expected 0", wb2rf_wren); end
    checks++; if (wb2ac_hazard !== 1'b0) begin errors++; $display("[TB] FAIL lh_hazard_after: got %b expected 0", wb2ac_hazard); end
  endtask

  task automatic test_alignment();
    for (int i = 0; i < 6; i++) begin
      drive_op(5'd12, 1'b1, 1'b1, 1'b1, tbl_bsel[i], tbl_off[i], 32'h0);
      tick(); drive_idle();
      dmem_resp_valid = 1'b1; dmem_resp_data = tbl_data[i]; #1;
      checks++; if (wb2rf_wdata !== tbl_exp[i]) begin errors++; $display("[TB] FAIL align_wdata[%0d]: got %h expected %h", i, wb2rf_wdata, tbl_exp[i]); end
      tick(); dmem_resp_valid = 1'b0;
    end
  endtask

  task automatic test_flush_drain();
    drive_op(5'd10, 1'b1, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
    tick(); drive_idle(); #1;
    checks++; if (wb2ac_hazard !== 1'b1) begin errors++; $display("[TB] FAIL drain_hazard_idle: got %b expected 1", wb2ac_hazard); end
    tick();
    ac2wb_flush = 1'b1; #1;
    checks++; if (wb2ac_hazard !== 1'b1) begin errors++; $display("[TB] FAIL drain_hazard_flush: got %b expected 1", wb2ac_hazard); end
    checks++; if (wb2rf_wren !== 1'b0) begin errors++; $display("[TB] FAIL drain_wren_flush: got %b expected 0", wb2rf_wren); end
    tick(); ac2wb_flush = 1'b0; #1;
    for (int c = 0; c < 2; c++) begin
      checks++; if (wb2ac_hazard !== 1'b1) begin errors++; $display("[TB] FAIL drain_hazard[%0d]: got %b expected 1", c, wb2ac_hazard); end
      checks++; if (wb2rf_wren !== 1'b0) begin errors++; $display("[TB] FAIL drain_wren[%0d]: got %b expected 0", c, wb2rf_wren); end
      tick();
    end
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'hDEAD_BEEF;
    drive_op(5'd11, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 32'hCAFE_F00D); #1;
    checks++; if (wb2rf_wren !== 1'b0) begin errors++; $display("[TB] FAIL drain_wren_resp: got %b expected 0", wb2rf_wren); end
    checks++; if (wb2ac_hazard !== 1'b0) begin errors++; $display("[TB] FAIL drain_hazard_resp: got %b expected 0", wb2ac_hazard); end
    tick(); dmem_resp_valid = 1'b0; drive_idle(); #1;
    checks++; if (wb2rf_wren !== 1'b1) begin errors++; $display("[TB] FAIL drain_next_wren: got %b expected 1", wb2rf_wren); end
    checks++; if (wb2rf_waddr !== 5'd11) begin errors++; $display("[TB] FAIL drain_next_waddr: got %0d expected 11", wb2rf_waddr); end
    checks++; if (wb2rf_wdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL drain_next_wdata: got %h expected cafef00d", wb2rf_wdata); end
    tick();
  endtask

  task automatic test_store_rd0();
`ifdef WB_INSTRET_EN
    instret_base = wb2csr_instret;
`endif
    drive_op(5'd3, 1'b0, 1'b0, 1'b1, 3'b010, 2'd0, 32'h0000_0040);
    tick(); drive_idle(); #1;
    checks++; if (wb2ac_hazard !== 1'b1) begin errors++; $display("[TB] FAIL store_hazard: got %b expected 1", wb2ac_hazard); end
    checks++; if (wb2rf_wren !== 1'b0) begin errors++; $display("[TB] FAIL store_wren_wait: got %b expected 0", wb2rf_wren); end
    tick();
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'h1111_1111; #1;
    checks++; if (wb2ac_hazard !== 1'b0) begin errors++; $display("[TB] FAIL store_hazard_done: got %b expected 0", wb2ac_hazard); end
    checks++; if (wb2rf_wren !== 1'b0) begin errors++; $display("[TB] FAIL store_wren_done: got %b expected 0", wb2rf_wren); end
    tick(); dmem_resp_valid = 1'b0;
    drive_op(5'd0, 1'b1, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
    tick(); drive_idle();
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'h2222_2222; #1;
    checks++; if (wb2rf_wren !== 1'b0) begin errors++; $display("[TB] FAIL rd0_wren: got %b expected 0", wb2rf_wren); end
    checks++; if (wb2ac_hazard !== 1'b0) begin errors++; $display("[TB] FAIL rd0_hazard: got %b expected 0", wb2ac_hazard); end
    tick(); dmem_resp_valid = 1'b0; #1;
`ifdef WB_INSTRET_EN
    checks++; if (wb2csr_instret !== instret_base + 64'd2) begin errors++; $display("[TB] FAIL instret_delta: got %0d expected %0d", wb2csr_instret, instret_base + 64'd2); end
`endif
  endtask

  task automatic test_back_to_back();
    drive_op(5'd1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 32'hAAAA_0001);
    tick();
    drive_op(5'd2, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 32'hBBBB_0002); #1;
    checks++; if (wb2rf_waddr !== 5'd1 || wb2rf_wdata !== 32'hAAAA_0001 || wb2rf_wren !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first: got %0d/%h/%b expected 1/aaaa0001/1", wb2rf_waddr, wb2rf_wdata, wb2rf_wren); end
    tick();
    ac2wb_stall = 1'b1;
    drive_op(5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 32'hCCCC_0003); #1;
    checks++; if (wb2rf_waddr !== 5'd2 || wb2rf_wdata !== 32'hBBBB_0002) begin errors++; $display("[TB] FAIL b2b_second: got %0d/%h expected 2/bbbb0002", wb2rf_waddr, wb2rf_wdata); end
    tick(); #1;
    checks++; if (wb2rf_waddr !== 5'd2 || wb2rf_wdata !== 32'hBBBB_0002) begin errors++; $display("[TB] FAIL b2b_stall_hold: got %0d/%h expected 2/bbbb0002", wb2rf_waddr, wb2rf_wdata); end
    ac2wb_stall = 1'b0;
    tick(); drive_idle(); #1;
    checks++; if (wb2rf_waddr !== 5'd3 || wb2rf_wdata !== 32'hCCCC_0003 || wb2rf_wren !== 1'b1) begin errors++; $display("[TB] FAIL b2b_after_stall: got %0d/%h/%b expected 3/cccc0003/1", wb2rf_waddr, wb2rf_wdata, wb2rf_wren); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    drive_op(5'd14, 1'b1, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
    tick(); drive_idle();
    tick(); #1;
    checks++; if (wb2ac_hazard !== 1'b1) begin errors++; $display("[TB] FAIL rstwait_hazard_before: got %b expected 1", wb2ac_hazard); end
    rst = 1'b1;
    tick(); #1;
    checks++; if (wb2ac_hazard !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_hazard: got %b expected 0", wb2ac_hazard); end
    checks++; if (wb2rf_wren !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_wren: got %b expected 0", wb2rf_wren); end
`ifdef WB_INSTRET_EN
    checks++; if (wb2csr_instret !== 64'd0) begin errors++; $display("[TB] FAIL rstwait_instret: got %0d expected 0", wb2csr_instret); end
`endif
    rst = 1'b0;
    drive_op(5'd15, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 32'h0BAD_F00D);
    tick(); drive_idle(); #1;
    checks++; if (wb2rf_wren !== 1'b1 || wb2rf_wdata !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL rstwait_next_alu: got %b/%h expected 1/0badf00d", wb2rf_wren, wb2rf_wdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb_immediate();
    test_lh_delayed();
    test_alignment();
    test_flush_drain();
    test_store_rd0();
    test_back_to_back();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
